umi_regbank: RTL and testbench
==============================

// Module: umi_regbank
// PURPOSE
//  Register bank that sits directly downstream of the UMI register interface.
//  It consumes the reg_addr/reg_read/reg_write/reg_size/reg_wrdata strobes
//  and returns reg_rddata, registered and held until the next read.
//  It provides a control register, sticky W1C status with interrupt, a
//  gated free-running counter, and general scratch registers.
// PARAMETERS
//  AW     64  address width of reg_addr
//  RW     64  register width; power of 2, >=32
//  NREG   16  number of registers, >=5; must satisfy NREG <= 2^(REGAW-BL)
//  REGAW  8   low byte-address bits decoded; upper bits ignored
//             (group select is done upstream)
// PORTS
//  clk         in   1      clock
//  nreset      in   1      async active-low reset
//  reg_addr    in   AW     byte address
//  reg_write   in   1      single-cycle write strobe
//  reg_read    in   1      single-cycle read strobe
//  reg_size    in   3      log2(bytes) of write access
//  reg_wrdata  in   RW     write data, byte lanes aligned to register
//  reg_rddata  out  RW     registered read data
//  hw_event    in   RW     per-bit event pulses into STATUS
//  ctrl        out  RW     CTRL register contents
//  irq         out  1      registered interrupt
// BEHAVIOUR
//  - One clock, asynchronous active-low reset. Reset values: all registers 0,
//    reg_rddata=0, ctrl=0, irq=0.
//  - Decode: BL=log2(RW/8); idx=reg_addr[REGAW-1:BL]; off=reg_addr[BL-1:0].
//    idx>=NREG: write ignored, read returns 0.
//  - Register map:
//    0 CTRL   RW; bit0 = counter enable.
//    1 STATUS sticky; bit i set when hw_event[i]=1. Writing 1 clears bit i.
//      Set and clear of the same bit in the same cycle: set wins (bit stays 1).
//    2 IRQEN  RW.
//    3 COUNT  +1 per cycle while CTRL[0]=1; wraps 2^RW-1 -> 0.
//      A write loads the written bytes; no increment in that cycle.
//    4..NREG-1 scratch RW.
//  - Write byte mask: nb=2^reg_size. Bytes off..off+nb-1 are enabled, clipped
//    to the register top. reg_size>BL means a full-width write. Byte k of the
//    register takes reg_wrdata[8k+:8]. Writes take effect on the clock edge
//    where reg_write=1.
//  - Read: full RW-bit register regardless of size/off. reg_rddata is loaded on
//    the edge where reg_read=1 (value visible next cycle) and held stable until
//    the next reg_read.
//  - reg_read and reg_write together (not produced upstream): the write is
//    performed and the read returns the pre-write value.
//  - irq: registered version of |(STATUS & IRQEN), 1-cycle lag after the
//    STATUS/IRQEN update.
//  - Reset mid-operation: all state returns to reset values asynchronously;
//    no pending accesses survive.
// TESTING
//  1. Reset, then read idx0..NREG-1: reg_rddata=0 for each; irq=0; ctrl=0.
//  2. Write scratch idx4 with addr=0x20, size=3, data=0x1122334455667788.
//     Then write addr=0x22, size=1, data lanes 2-3=0xAAAA.
//     A read of 0x20 returns 0x11223344AAAA7788, valid the cycle after
//     reg_read and held.
//  3. Set IRQEN=0x4 and pulse hw_event=0x6. STATUS reads 0x6 and irq=1
//     within 2 cycles. Write STATUS=0x4 in the same cycle as hw_event[2]=1:
//     STATUS stays 0x6. Write 0x4 again with no event: STATUS=0x2, irq=0.
//  4. Write COUNT=0xFFFFFFFFFFFFFFFE, then CTRL=1, and wait 3 cycles:
//     COUNT has wrapped to 0x1.
//     A write of COUNT=0x10 while enabled reads back 0x10 plus elapsed cycles.
//  5. Write idx 20 (addr=0xA0) and read it: reg_rddata=0, no register changes.
//  6. Assert nreset low mid-count with IRQ pending: all outputs 0 immediately.

Source files
------------

// File: rtl/umi_regbank.sv
// umi_regbank
//   Register bank fed by the UMI register-interface strobes. It holds a control
//   register, a sticky write-one-to-clear status register with interrupt enable,
//   a gated free-running counter and general scratch registers.
//
// Register map (index = reg_addr[REGAW-1:BL], BL = log2(RW/8)):
//   0 CTRL    read/write, bit 0 enables the counter
//   1 STATUS  sticky event bits, write 1 to clear, a new event wins over a clear
//   2 IRQEN   read/write interrupt enable mask
//   3 COUNT   increments while CTRL[0]=1; a write loads the written bytes
//   4..NREG-1 scratch read/write
//   Indices >= NREG ignore writes and read as 0.
//
// Ports:
//   clk, nreset            clock, asynchronous active-low reset
//   reg_addr               byte address; only the low REGAW bits are decoded
//   reg_write, reg_read    single-cycle access strobes
//   reg_size               log2(bytes) of a write; above BL means full width
//   reg_wrdata             write data, byte lanes aligned to the register
//   reg_rddata             registered read data, held until the next read
//   hw_event               per-bit event pulses into STATUS
//   ctrl                   CTRL register contents
//   irq                    registered |(STATUS & IRQEN)
module umi_regbank #(
    parameter int AW    = 64,
    parameter int RW    = 64,
    parameter int NREG  = 16,
    parameter int REGAW = 8
) (
    input  logic          clk,
    input  logic          nreset,
    input  logic [AW-1:0] reg_addr,
    input  logic          reg_write,
    input  logic          reg_read,
    input  logic [2:0]    reg_size,
    input  logic [RW-1:0] reg_wrdata,
    output logic [RW-1:0] reg_rddata,
    input  logic [RW-1:0] hw_event,
    output logic [RW-1:0] ctrl,
    output logic          irq
);

    localparam int NB = RW / 8;
    localparam int BL = $clog2(NB);
    localparam int IW = REGAW - BL;
    // Wide enough to hold off + 2^BL without overflow
    localparam int MW = BL + 2;

    logic [RW-1:0] r_regs [NREG];
    logic [RW-1:0] r_rddata;
    logic          r_irq;

    logic [IW-1:0]   w_idx;
    logic [BL-1:0]   w_off;
    logic [MW-1:0]   w_lo;
    logic [MW-1:0]   w_hi;
    logic [NB-1:0]   w_bytemask;
    logic [RW-1:0]   w_bitmask;
    logic [NREG-1:0] w_hit;
    logic [RW-1:0]   w_rdsel;
    logic [RW-1:0]   w_next [NREG];
    logic            w_unused;

    assign w_idx = reg_addr[REGAW-1:BL];
    assign w_off = reg_addr[BL-1:0];
    // Upper address bits select the register group upstream and are not decoded here
    assign w_unused = &{1'b0, reg_addr[AW-1:REGAW]};

    // Byte enables: bytes off..off+2^size-1, clipped at the register top
    always_comb begin
        w_lo       = {2'b00, w_off};
        w_hi       = w_lo;
        w_bytemask = '0;
        if (reg_size > 3'(BL)) begin
            w_bytemask = '1;
        end else begin
            w_hi = w_lo + (MW'(1) << reg_size);
            for (int k = 0; k < NB; k++) begin
                if ((MW'(k) >= w_lo) && (MW'(k) < w_hi)) begin
                    w_bytemask[k] = 1'b1;
                end else begin
                    w_bytemask[k] = 1'b0;
                end
            end
        end
    end

    // Expand byte enables to a bit mask
    always_comb begin
        w_bitmask = '0;
        for (int k = 0; k < NB; k++) begin
            w_bitmask[8*k +: 8] = {8{w_bytemask[k]}};
        end
    end

    // Per-register write select and read mux; out-of-range indices match nothing
    always_comb begin
        w_hit   = '0;
        w_rdsel = '0;
        for (int i = 0; i < NREG; i++) begin
            if (w_idx == IW'(i)) begin
                w_hit[i] = reg_write;
                w_rdsel  = r_regs[i];
            end else begin
                w_hit[i] = 1'b0;
            end
        end
    end

    // Next-state value of every register
    always_comb begin
        for (int i = 0; i < NREG; i++) begin
            w_next[i] = r_regs[i];
            if (i == 1) begin
                // Clear first, then OR in events so a same-cycle event survives the clear
                w_next[i] = (r_regs[i] & ~(w_hit[i] ? (reg_wrdata & w_bitmask) : '0)) | hw_event;
            end else if (w_hit[i]) begin
                w_next[i] = (r_regs[i] & ~w_bitmask) | (reg_wrdata & w_bitmask);
            end else if ((i == 3) && r_regs[0][0]) begin
                w_next[i] = r_regs[i] + RW'(1);
            end else begin
                w_next[i] = r_regs[i];
            end
        end
    end

    // Register state, read-data capture and interrupt
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            for (int i = 0; i < NREG; i++) begin
                r_regs[i] <= '0;
            end
            r_rddata <= '0;
            r_irq    <= 1'b0;
        end else begin
            for (int i = 0; i < NREG; i++) begin
                r_regs[i] <= w_next[i];
            end
            // Read mux uses current values, so a simultaneous write returns pre-write data
            if (reg_read) begin
                r_rddata <= w_rdsel;
            end else begin
                r_rddata <= r_rddata;
            end
            r_irq <= |(r_regs[1] & r_regs[2]);
        end
    end

    assign reg_rddata = r_rddata;
    assign ctrl       = r_regs[0];
    assign irq        = r_irq;

endmodule

// File: tb/tb_umi_regbank.sv
// tb_umi_regbank
//   Drives umi_regbank with directed and random register accesses and compares
//   reg_rddata, ctrl and irq every cycle against a behavioural register model.
module tb_umi_regbank;

    logic        clk = 1'b0;
    logic        nreset = 1'b0;
    logic [63:0] reg_addr;
    logic        reg_write;
    logic        reg_read;
    logic [2:0]  reg_size;
    logic [63:0] reg_wrdata;
    logic [63:0] reg_rddata;
    logic [63:0] hw_event;
    logic [63:0] ctrl;
    logic        irq;

    int n_checks = 0;
    int n_errs   = 0;

    logic [63:0] m_regs [16];
    logic [63:0] m_rd;
    logic        m_irq;

    always #5 clk = ~clk;

    umi_regbank dut (
        .clk        (clk),
        .nreset     (nreset),
        .reg_addr   (reg_addr),
        .reg_write  (reg_write),
        .reg_read   (reg_read),
        .reg_size   (reg_size),
        .reg_wrdata (reg_wrdata),
        .reg_rddata (reg_rddata),
        .hw_event   (hw_event),
        .ctrl       (ctrl),
        .irq        (irq)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errs++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 16; i++) m_regs[i] = 64'd0;
        m_rd  = 64'd0;
        m_irq = 1'b0;
    endtask

    // One clock edge of the register bank, applied to the model from pre-edge state
    task automatic model_step(input logic wr, input logic rd, input logic [63:0] addr,
                              input logic [2:0] size, input logic [63:0] data,
                              input logic [63:0] ev);
        logic [63:0] old [16];
        logic [63:0] mask;
        int idx, off, nb;
        old  = m_regs;
        idx  = int'(addr[7:3]);
        off  = int'(addr[2:0]);
        nb   = 1 << size;
        mask = 64'd0;
        for (int b = 0; b < 8; b++) begin
            if (size > 3'd3 || (b >= off && b < off + nb)) mask[8*b +: 8] = 8'hFF;
        end
        if (rd) m_rd = (idx < 16) ? old[idx] : 64'd0;
        m_irq = |(old[1] & old[2]);
        if (old[0][0]) m_regs[3] = old[3] + 64'd1;
        m_regs[1] = old[1] | ev;
        if (wr && idx < 16) begin
            if (idx == 1) m_regs[1] = (old[1] & ~(data & mask)) | ev;
            else          m_regs[idx] = (old[idx] & ~mask) | (data & mask);
        end
    endtask

    task automatic do_cycle(input logic wr, input logic rd, input logic [63:0] addr,
                            input logic [2:0] size, input logic [63:0] data,
                            input logic [63:0] ev);
        reg_write  = wr;
        reg_read   = rd;
        reg_addr   = addr;
        reg_size   = size;
        reg_wrdata = data;
        hw_event   = ev;
        @(posedge clk);
        model_step(wr, rd, addr, size, data, ev);
        #1;
        check("rddata", reg_rddata, m_rd);
        check("ctrl", ctrl, m_regs[0]);
        check("irq", {63'd0, irq}, {63'd0, m_irq});
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) do_cycle(1'b0, 1'b0, 64'd0, 3'd0, 64'd0, 64'd0);
    endtask

    task automatic wr(input logic [63:0] addr, input logic [2:0] size,
                      input logic [63:0] data, input logic [63:0] ev);
        do_cycle(1'b1, 1'b0, addr, size, data, ev);
    endtask

    task automatic rd(input logic [63:0] addr);
        do_cycle(1'b0, 1'b1, addr, 3'd3, 64'd0, 64'd0);
    endtask

    initial begin
        reg_addr   = 64'd0;
        reg_write  = 1'b0;
        reg_read   = 1'b0;
        reg_size   = 3'd0;
        reg_wrdata = 64'd0;
        hw_event   = 64'd0;
        model_reset();

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_rddata", reg_rddata, 64'd0);
        check("rst_ctrl", ctrl, 64'd0);
        check("rst_irq", {63'd0, irq}, 64'd0);
        @(negedge clk);
        nreset = 1'b1;

        // All registers read 0 after reset
        for (int i = 0; i < 16; i++) begin
            rd(64'(i * 8));
            check("t1_rd_zero", reg_rddata, 64'd0);
        end

        // Partial-width write into a scratch register, read held stable
        wr(64'h20, 3'd3, 64'h1122334455667788, 64'd0);
        wr(64'h22, 3'd1, 64'h00000000AAAA0000, 64'd0);
        rd(64'h20);
        check("t2_scratch", reg_rddata, 64'h11223344AAAA7788);
        idle(2);
        check("t2_held", reg_rddata, 64'h11223344AAAA7788);

        // Sticky status, interrupt, set-wins-over-clear
        wr(64'h10, 3'd3, 64'h4, 64'd0);
        do_cycle(1'b0, 1'b0, 64'd0, 3'd0, 64'd0, 64'h6);
        rd(64'h08);
        check("t3_status", reg_rddata, 64'h6);
        check("t3_irq_on", {63'd0, irq}, 64'd1);
        wr(64'h08, 3'd3, 64'h4, 64'h4);
        rd(64'h08);
        check("t3_set_wins", reg_rddata, 64'h6);
        wr(64'h08, 3'd3, 64'h4, 64'd0);
        rd(64'h08);
        check("t3_cleared", reg_rddata, 64'h2);
        check("t3_irq_off", {63'd0, irq}, 64'd0);

        // Counter wrap and load while enabled
        wr(64'h18, 3'd3, 64'hFFFFFFFFFFFFFFFE, 64'd0);
        wr(64'h00, 3'd3, 64'h1, 64'd0);
        idle(3);
        rd(64'h18);
        check("t4_wrap", reg_rddata, 64'h1);
        wr(64'h18, 3'd3, 64'h10, 64'd0);
        idle(1);
        rd(64'h18);
        check("t4_load", reg_rddata, 64'h11);

        // Out-of-range index: write ignored, reads 0
        wr(64'hA0, 3'd3, 64'hFFFFFFFFFFFFFFFF, 64'd0);
        rd(64'hA0);
        check("t5_oor_rd", reg_rddata, 64'd0);
        rd(64'h20);
        check("t5_scratch_kept", reg_rddata, 64'h11223344AAAA7788);
        for (int i = 0; i < 16; i++) rd(64'(i * 8));

        // Asynchronous reset mid-count with interrupt pending
        wr(64'h10, 3'd3, 64'h6, 64'd0);
        idle(2);
        check("t6_irq_pending", {63'd0, irq}, 64'd1);
        rd(64'h18);
        #2;
        nreset = 1'b0;
        #1;
        check("t6_rst_rddata", reg_rddata, 64'd0);
        check("t6_rst_ctrl", ctrl, 64'd0);
        check("t6_rst_irq", {63'd0, irq}, 64'd0);
        model_reset();
        @(negedge clk);
        nreset = 1'b1;
        idle(1);
        rd(64'h18);
        check("t6_count_zero", reg_rddata, 64'd0);

        // Random accesses against the model
        for (int n = 0; n < 400; n++) begin
            logic [63:0] a;
            a      = {$urandom, $urandom};
            a[7:0] = 8'($urandom_range(0, 159));
            do_cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), a,
                     3'($urandom_range(0, 7)), {$urandom, $urandom},
                     {$urandom, $urandom} & {$urandom, $urandom} & {$urandom, $urandom});
        end
        for (int i = 0; i < 16; i++) rd(64'(i * 8));

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

endmodule
